spi_frame_slave: RTL

//  Parametrised SPI slave for the trigger FPGA: full-duplex, configurable mode, frame length and bit order.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_pin_sync.sv | 34 +++
 rtl/spi_frame_slave.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - state encoding and SCLK edge helpers shared by the SPI frame slave
package spi_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_ARMED = 2'd1;
  localparam logic [1:0] ENC_SHIFT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_ARMED = ENC_ARMED,
    ST_SHIFT = ENC_SHIFT
  } spi_state_e;

  // Cycles after reset release during which a low CS_N is treated as a
  // frame that was already running (sync pipeline depth plus one).
  localparam int SETTLE_W = 3;

  // Leading edge leaves the idle level: rising for CPOL=0, falling for CPOL=1.
  function automatic logic lead_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? fall : rise;
  endfunction

  function automatic logic trail_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? rise : fall;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - two-flop pin synchroniser with one-cycle edge detector
module spi_pin_sync #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic sampling_clk,
  input  logic rst,
  input  logic pin_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  // Metastability pair followed by a delay flop so edges are seen for one cycle
  always_ff @(posedge sampling_clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      dly  <= RST_VAL;
    end else begin
      meta <= pin_async;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~dly;
  assign fall  = ~sync & dly;

endmodule

// File: rtl/spi_frame_slave.sv
// rtl/spi_frame_slave.sv - oversampled full-duplex SPI slave with fixed frame length
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_SO   = 1'b0
) (
  input  logic              sampling_clk,
  input  logic              rst,
  input  logic              sclk_async,
  input  logic              cs_n_async,
  input  logic              mosi_async,
  output logic              so,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;
  logic mosi_level;
  // MOSI is only ever sampled as a level on an SCLK edge
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  spi_pin_sync #(.RST_VAL(CPOL)) u_sync_sclk (
    .sampling_clk (sampling_clk),
    .rst          (rst),
    .pin_async    (sclk_async),
    .level        (sclk_level_unused),
    .rise         (sclk_rise),
    .fall         (sclk_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b1)) u_sync_cs_n (
    .sampling_clk (sampling_clk),
    .rst          (rst),
    .pin_async    (cs_n_async),
    .level        (cs_level),
    .rise         (cs_rise),
    .fall         (cs_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .sampling_clk (sampling_clk),
    .rst          (rst),
    .pin_async    (mosi_async),
    .level        (mosi_level),
    .rise         (mosi_rise_unused),
    .fall         (mosi_fall_unused)
  );

  logic sample_edge;
  logic shift_edge;

  assign sample_edge = CPHA ? trail_edge(CPOL, sclk_rise, sclk_fall)
                            : lead_edge(CPOL, sclk_rise, sclk_fall);
  assign shift_edge  = CPHA ? lead_edge(CPOL, sclk_rise, sclk_fall)
                            : trail_edge(CPOL, sclk_rise, sclk_fall);

  logic [DATA_W-1:0] tx_ordered;
  logic [DATA_W-1:0] rx_shifted;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CNT_W-1:0]  count;
  logic              over;
  logic [SETTLE_W-1:0] settle;
  spi_state_e        state;

  // Transmit register always shifts out of its MSB; LSB-first frames are reversed on load
  always_comb begin
    tx_ordered = tx_data;
    if (LSB_FIRST) begin
      for (int i = 0; i < DATA_W; i++) begin
        tx_ordered[i] = tx_data[DATA_W-1-i];
      end
    end
  end

  assign rx_shifted = LSB_FIRST ? {mosi_level, rx_sr[DATA_W-1:1]}
                                : {rx_sr[DATA_W-2:0], mosi_level};

  // Frame FSM: load on CS_N fall, sample/shift on SCLK edges, close and flag on CS_N rise
  always_ff @(posedge sampling_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data   <= '0;
      count     <= '0;
      over      <= 1'b0;
      so        <= IDLE_SO;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      settle    <= '1;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      settle    <= settle >> 1;
      case (state)
        ST_IDLE: begin
          if (settle != '0 && !cs_level) begin
            // CS_N was already low when reset let go: wait for this frame to end
            state <= ST_ARMED;
          end else if (cs_fall) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
            count <= '0;
            over  <= 1'b0;
            rx_sr <= '0;
            if (CPHA) begin
              so    <= IDLE_SO;
              tx_sr <= tx_ordered;
            end else begin
              so    <= tx_ordered[DATA_W-1];
              tx_sr <= {tx_ordered[DATA_W-2:0], IDLE_SO};
            end
          end
        end
        ST_ARMED: begin
          if (cs_rise) begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            // CS_N rise takes precedence over any SCLK edge detected in the same cycle
            state <= ST_IDLE;
            busy  <= 1'b0;
            so    <= IDLE_SO;
            if (count == FULL && !over) begin
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sample_edge) begin
              if (count == FULL) begin
                over <= 1'b1;
              end else begin
                rx_sr <= rx_shifted;
                count <= count + 1'b1;
                // CPHA=1 has no shift edge after the last sample, so release SO here
                if (CPHA && count == FULL - 1'b1) begin
                  so <= IDLE_SO;
                end
              end
            end
            // Back-filling with IDLE_SO parks SO at idle once every bit is out
            if (shift_edge && (CPHA || count != '0)) begin
              so    <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], IDLE_SO};
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
